// File: rtl/program_loader.sv
// Builds the controller's instruction stream in feature memory: validates layer descriptors,
// packs them into 32-bit words and writes them downward from PC_START, closing with END.
module program_loader #(
  parameter int unsigned PC_START   = 4095,
  parameter int unsigned PROG_DEPTH = 64,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              flush,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [3:0]        desc_op,
  input  logic [7:0]        desc_num,
  input  logic [13:0]       desc_size,
  input  logic [5:0]        desc_ksize,
  input  logic [3:0]        desc_stride,
  input  logic [3:0]        desc_class,
  input  logic [9:0]        desc_mstart,
  output logic [ADDR_W-1:0] feature_addr,
  output logic [31:0]       feature_data,
  output logic              feature_en,
  output logic [7:0]        instr_count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [31:0] EndWord = 32'h4000_0000;
  localparam logic [3:0]  OpConv  = 4'd1;
  localparam logic [3:0]  OpPool  = 4'd2;
  localparam logic [3:0]  OpFc    = 4'd3;
  localparam logic [3:0]  OpEnd   = 4'd4;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrOp    = 2'd1;
  localparam logic [1:0] ErrRange = 2'd2;
  localparam logic [1:0] ErrFull  = 2'd3;

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              is_end_q, is_end_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0] enc_word;
  logic [1:0]  chk_code;
  logic        full;
  logic        restart;

  assign full    = (count_q == 8'(PROG_DEPTH - 1));
  assign restart = load_start && ((state_q == StIdle) || (state_q == StDone));

  // Encode and validate the presented descriptor; chk_code is ErrNone when it may be written.
  always_comb begin
    enc_word = EndWord;
    chk_code = ErrNone;
    case (desc_op)
      OpConv: begin
        enc_word = {OpConv, desc_stride, desc_num, desc_ksize[3:0], desc_size[11:0]};
        if ((desc_size[13:12] != 2'd0) || (desc_ksize[5:4] != 2'd0) || (desc_ksize == 6'd0) ||
            ({8'd0, desc_ksize} > desc_size) || (desc_stride == 4'd0)) begin
          chk_code = ErrRange;
        end
      end
      OpPool: begin
        enc_word = {OpPool, desc_num, desc_ksize, desc_size};
        if ((desc_ksize == 6'd0) || (desc_num == 8'd0)) chk_code = ErrRange;
      end
      OpFc: begin
        enc_word = {OpFc, desc_num, desc_ksize, desc_class, desc_mstart};
        if ((desc_class == 4'd0) || (desc_num == 8'd0)) chk_code = ErrRange;
      end
      OpEnd:   enc_word = EndWord;
      default: chk_code = ErrOp;
    endcase
    // The last slot is reserved for END so a program can always be terminated.
    if (full && (desc_op != OpEnd)) chk_code = ErrFull;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (load_start) state_d = StAccept;
      StAccept: begin
        if (flush)                                   state_d = StWrite;
        else if (desc_valid && (chk_code == ErrNone)) state_d = StWrite;
      end
      StWrite:  state_d = is_end_q ? StDone : StAccept;
      StDone:   if (load_start) state_d = StAccept;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    desc_ready   = (state_q == StAccept) && !flush;
    feature_en   = (state_q == StWrite);
    feature_addr = feature_en ? ptr_q : '0;
    feature_data = feature_en ? word_q : '0;
    done         = (state_q == StDone);
    instr_count  = count_q;
    err          = err_q;
    err_code     = err_code_q;
  end

  always_comb begin
    ptr_d      = ptr_q;
    count_d    = count_q;
    word_d     = word_q;
    is_end_d   = is_end_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    if (restart) begin
      ptr_d      = ADDR_W'(PC_START);
      count_d    = 8'd0;
      err_code_d = ErrNone;
    end
    if (state_q == StAccept) begin
      if (flush) begin
        word_d   = EndWord;
        is_end_d = 1'b1;
      end else if (desc_valid) begin
        if (chk_code == ErrNone) begin
          word_d   = enc_word;
          is_end_d = (desc_op == OpEnd);
        end else begin
          err_d      = 1'b1;
          err_code_d = chk_code;
        end
      end
    end
    if (state_q == StWrite) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= ADDR_W'(PC_START);
      count_q    <= 8'd0;
      word_q     <= 32'd0;
      is_end_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      is_end_q   <= is_end_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected writes are queued when a descriptor is driven
// and matched against each feature_en pulse.
module tb_program_loader;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset, load_start, flush, desc_valid, desc_ready;
  logic [3:0]  desc_op, desc_stride, desc_class;
  logic [7:0]  desc_num;
  logic [13:0] desc_size;
  logic [5:0]  desc_ksize;
  logic [9:0]  desc_mstart;
  logic [11:0] feature_addr;
  logic [31:0] feature_data;
  logic        feature_en, done, err;
  logic [7:0]  instr_count;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;
  logic [43:0] sb[$];
  logic [11:0] exp_ptr;

  program_loader #(.PC_START(4095), .PROG_DEPTH(Depth), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .flush(flush),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_op(desc_op),
    .desc_num(desc_num), .desc_size(desc_size), .desc_ksize(desc_ksize),
    .desc_stride(desc_stride), .desc_class(desc_class), .desc_mstart(desc_mstart),
    .feature_addr(feature_addr), .feature_data(feature_data), .feature_en(feature_en),
    .instr_count(instr_count), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (feature_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", {31'd0, feature_en}, 32'd0);
      end else begin
        logic [43:0] e;
        e = sb.pop_front();
        check("write_addr", {20'd0, feature_addr}, {20'd0, e[43:32]});
        check("write_data", feature_data, e[31:0]);
      end
    end
  end

  task automatic start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    exp_ptr = 12'd4095;
  endtask

  // Called just after a posedge; returns just after the posedge two cycles past acceptance.
  task automatic send(input logic [3:0] op, input logic [7:0] num, input logic [13:0] size,
                      input logic [5:0] ksize, input logic [3:0] stride, input logic [3:0] cls,
                      input logic [9:0] mstart, input logic [31:0] exp_word,
                      input logic [1:0] exp_code);
    int n = 0;
    desc_op = op; desc_num = num; desc_size = size; desc_ksize = ksize;
    desc_stride = stride; desc_class = cls; desc_mstart = mstart;
    desc_valid = 1'b1;
    @(negedge clk);
    while (desc_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("desc_ready_wait", {31'd0, desc_ready}, 32'd1);
    if (exp_code == 2'd0) begin
      sb.push_back({exp_ptr, exp_word});
      exp_ptr = exp_ptr - 12'd1;
    end
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(negedge clk);
    check("feature_en_t1", {31'd0, feature_en}, {31'd0, exp_code == 2'd0});
    check("err_t1", {31'd0, err}, {31'd0, exp_code != 2'd0});
    if (exp_code != 2'd0) check("err_code", {30'd0, err_code}, {30'd0, exp_code});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; flush = 1'b0; desc_valid = 1'b0;
    desc_op = '0; desc_num = '0; desc_size = '0; desc_ksize = '0;
    desc_stride = '0; desc_class = '0; desc_mstart = '0;
    exp_ptr = 12'd4095;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_feature_en", {31'd0, feature_en}, 32'd0);
    check("rst_ready", {31'd0, desc_ready}, 32'd0);
    check("rst_count", {24'd0, instr_count}, 32'd0);
    check("rst_err", {29'd0, err, err_code}, 32'd0);
    check("rst_addr", {20'd0, feature_addr}, 32'd0);
    @(posedge clk); #1;

    // Plan 1 and 2: full legal program
    start();
    send(4'd1, 8'd6, 14'd28, 6'd5, 4'd1, 4'd0, 10'd0, 32'h1106501C, 2'd0);
    check("count_after_conv", {24'd0, instr_count}, 32'd1);
    send(4'd2, 8'd6, 14'd24, 6'd2, 4'd0, 4'd0, 10'd0, 32'h20608018, 2'd0);
    send(4'd3, 8'd6, 14'd0, 6'd12, 4'd0, 4'd10, 10'd940, 32'h30632BAC, 2'd0);
    send(4'd4, 8'd0, 14'd0, 6'd0, 4'd0, 4'd0, 10'd0, 32'h40000000, 2'd0);
    @(negedge clk);
    check("done_after_end", {31'd0, done}, 32'd1);
    check("count_after_end", {24'd0, instr_count}, 32'd4);
    check("ready_in_done", {31'd0, desc_ready}, 32'd0);
    @(posedge clk); #1;

    // Plan 3: illegal op and out-of-range field, pointer unchanged
    start();
    check("err_code_cleared", {30'd0, err_code}, 32'd0);
    send(4'd7, 8'd6, 14'd28, 6'd5, 4'd1, 4'd0, 10'd0, 32'h0, 2'd1);
    send(4'd1, 8'd6, 14'd28, 6'd0, 4'd1, 4'd0, 10'd0, 32'h0, 2'd2);
    send(4'd1, 8'd6, 14'd28, 6'd5, 4'd0, 4'd0, 10'd0, 32'h0, 2'd2);
    send(4'd1, 8'd6, 14'd4, 6'd5, 4'd1, 4'd0, 10'd0, 32'h0, 2'd2);
    send(4'd1, 8'd6, 14'd28, 6'd5, 4'd1, 4'd0, 10'd0, 32'h1106501C, 2'd0);

    // Plan 4: program full at Depth-1 words, END still fits
    send(4'd2, 8'd6, 14'd24, 6'd2, 4'd0, 4'd0, 10'd0, 32'h20608018, 2'd0);
    send(4'd3, 8'd6, 14'd0, 6'd12, 4'd0, 4'd10, 10'd940, 32'h30632BAC, 2'd0);
    send(4'd1, 8'd6, 14'd28, 6'd5, 4'd1, 4'd0, 10'd0, 32'h0, 2'd3);
    send(4'd1, 8'd6, 14'd28, 6'd0, 4'd1, 4'd0, 10'd0, 32'h0, 2'd3);
    send(4'd4, 8'd0, 14'd0, 6'd0, 4'd0, 4'd0, 10'd0, 32'h40000000, 2'd0);
    @(negedge clk);
    check("full_done", {31'd0, done}, 32'd1);
    check("full_count", {24'd0, instr_count}, 32'd4);
    check("err_code_held", {30'd0, err_code}, 32'd3);
    @(posedge clk); #1;

    // Plan 5: flush wins over a valid descriptor
    start();
    send(4'd1, 8'd6, 14'd28, 6'd5, 4'd1, 4'd0, 10'd0, 32'h1106501C, 2'd0);
    flush = 1'b1; desc_valid = 1'b1; desc_op = 4'd2;
    @(negedge clk);
    check("ready_under_flush", {31'd0, desc_ready}, 32'd0);
    sb.push_back({exp_ptr, 32'h40000000});
    @(posedge clk); #1;
    flush = 1'b0; desc_valid = 1'b0;
    @(negedge clk);
    check("flush_write", {31'd0, feature_en}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_done", {31'd0, done}, 32'd1);
    check("flush_count", {24'd0, instr_count}, 32'd2);
    @(posedge clk); #1;

    // Plan 6: reset during WRITE abandons the program
    start();
    desc_op = 4'd1; desc_num = 8'd6; desc_size = 14'd28; desc_ksize = 6'd5; desc_stride = 4'd1;
    desc_valid = 1'b1;
    sb.push_back({exp_ptr, 32'h1106501C});
    @(posedge clk); #1;
    desc_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_feature_en", {31'd0, feature_en}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_ready", {31'd0, desc_ready}, 32'd0);
    @(posedge clk); #1;
    start();
    send(4'd2, 8'd6, 14'd24, 6'd2, 4'd0, 4'd0, 10'd0, 32'h20608018, 2'd0);
    check("restart_count", {24'd0, instr_count}, 32'd1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
